rr_arbiter_4: RTL

Four-requester round-robin arbiter that grants one requester at a time. It holds the grant until the holder releases it or a hold timeout expires. It emits the winner as a registered 2-bit index with a valid flag. It sits directly upstream of the 2-to-4 decoder, which turns `grant_idx` into one-hot enables gated by `grant_valid`.

---
 rtl/rr_arbiter_4_pkg.sv | 23 ++
 rtl/rr_arbiter_4_pick4.sv | 27 ++
 rtl/rr_arbiter_4.sv | 86 ++++++++
 3 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Holds the FSM state encoding and the rotated-index helper used by the picker.
package arb_pkg;

   localparam int unsigned ARB_N     = 4;
   localparam int unsigned ARB_IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Index 'off' positions after 'base', wrapping modulo ARB_N.
   function automatic logic [ARB_IDX_W-1:0] idx_add(
      input logic [ARB_IDX_W-1:0] base,
      input int unsigned          off
   );
      logic [ARB_IDX_W-1:0] w_off;
      w_off   = ARB_IDX_W'(off);
      idx_add = base + w_off;
   endfunction

endpackage

// File: rtl/rr_arbiter_4_pick4.sv
// Combinational rotated-priority search: first set request after 'last',
// scanning last+1 .. last+4 with wrap-around.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]     req,
   input  logic [ARB_IDX_W-1:0] last,
   output logic [ARB_IDX_W-1:0] win_idx,
   output logic                 any
);

   logic [ARB_IDX_W-1:0] w_cand;

   always_comb begin
      win_idx = '0;
      any     = 1'b0;
      w_cand  = '0;
      for (int unsigned k = 1; k <= ARB_N; k++) begin
         w_cand = idx_add(last, k);
         if (!any && req[w_cand]) begin
            win_idx = w_cand;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, done release and hold
// timeout. All outputs are registered; one IDLE cycle separates grants.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ARB_N-1:0]     req,
   input  logic                 done,
   output logic [ARB_IDX_W-1:0] grant_idx,
   output logic                 grant_valid,
   output logic                 timeout
);

   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

   arb_state_t           r_state;
   logic [ARB_IDX_W-1:0] r_last;
   logic [3:0]           r_hold_cnt;
   logic [ARB_IDX_W-1:0] r_grant_idx;
   logic                 r_grant_valid;
   logic                 r_timeout;

   logic [ARB_IDX_W-1:0] w_win_idx;
   logic                 w_any;
   logic                 w_holder_req;
   logic                 w_limit;
   logic                 w_release;

   rr_pick4 u_pick (
      .req     (req),
      .last    (r_last),
      .win_idx (w_win_idx),
      .any     (w_any)
   );

   // timeout is flagged only when the hold limit is the sole release cause
   assign w_holder_req = req[r_grant_idx];
   assign w_limit      = (r_hold_cnt == HOLD_LIMIT);
   assign w_release    = done | ~w_holder_req | w_limit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last        <= 2'd3;
         r_hold_cnt    <= '0;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_timeout <= 1'b0;
               if (w_any) begin
                  r_grant_idx   <= w_win_idx;
                  r_grant_valid <= 1'b1;
                  r_hold_cnt    <= '0;
                  r_state       <= BUSY;
               end
            end
            BUSY: begin
               if (w_release) begin
                  r_state       <= IDLE;
                  r_grant_valid <= 1'b0;
                  r_last        <= r_grant_idx;
                  r_hold_cnt    <= '0;
                  r_timeout     <= w_limit & ~done & w_holder_req;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 4'd1;
                  r_timeout  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign grant_idx   = r_grant_idx;
   assign grant_valid = r_grant_valid;
   assign timeout     = r_timeout;

endmodule
